z3_master_cycle: RTL and testbench

// Zorro III bus-master cycle initiator, the counterpart of the slave-side buffer control.

---
 rtl/z3_master_cycle.sv | 156 +++++++++++++++
 tb/tb_z3_master_cycle.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/z3_master_cycle.sv
// Zorro III bus-master cycle initiator.
// Sequences FCS_n / DOE / DS_n / READ / ADDR_OE for one local-master transfer.
// The cycle ends on target DTACK_n, on BERR_n, or on an internal timeout.
// The result is returned to the local master as a one-cycle L_ACK or L_BERR pulse.
module z3_master_cycle #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       CLK,
    input  logic       RESET_n,
    input  logic       MYBUS_n,
    input  logic       MASTER_n,
    input  logic       L_REQ,
    input  logic       L_READ,
    input  logic [3:0] L_BE,
    output logic       L_ACK,
    output logic       L_BERR,
    output logic       FCS_n,
    output logic       DOE,
    output logic [3:0] DS_n,
    output logic       READ,
    output logic       ADDR_OE,
    input  logic       DTACK_n,
    input  logic       BERR_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_WAIT,
        S_TERM,
        S_RECOV
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] dtk_sync_q;
    logic [SYNC_STAGES-1:0] berr_sync_q;
    logic                   dtk_s;
    logic                   berr_s;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [3:0]  be_q;
    logic        fcs_n_q;
    logic        doe_q;
    logic [3:0]  ds_n_q;
    logic        read_q;
    logic        addr_oe_q;
    logic        l_ack_q;
    logic        l_berr_q;

    logic        start_w;
    logic        wait_done_w;
    logic        wait_err_w;

    // Synchronise the asynchronous target responses; idle level is high.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            dtk_sync_q  <= '1;
            berr_sync_q <= '1;
        end else begin
            dtk_sync_q  <= {dtk_sync_q[SYNC_STAGES-2:0], DTACK_n};
            berr_sync_q <= {berr_sync_q[SYNC_STAGES-2:0], BERR_n};
        end
    end

    assign dtk_s  = dtk_sync_q[SYNC_STAGES-1];
    assign berr_s = berr_sync_q[SYNC_STAGES-1];

    // Start and termination decisions; BERR beats DTACK, DTACK beats the timeout.
    always_comb begin
        start_w     = L_REQ && !MYBUS_n && !MASTER_n && dtk_s && berr_s;
        wait_done_w = !berr_s || !dtk_s || (cnt_q == CNT_LAST);
        wait_err_w  = !berr_s || (dtk_s && (cnt_q == CNT_LAST));
    end

    // Cycle sequencer; outputs are registered and take the value of the state being entered.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            be_q      <= '0;
            fcs_n_q   <= 1'b1;
            doe_q     <= 1'b0;
            ds_n_q    <= '1;
            read_q    <= 1'b1;
            addr_oe_q <= 1'b0;
            l_ack_q   <= 1'b0;
            l_berr_q  <= 1'b0;
        end else begin
            l_ack_q  <= 1'b0;
            l_berr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (start_w) begin
                        state_q   <= S_ADDR;
                        addr_oe_q <= 1'b1;
                        fcs_n_q   <= 1'b0;
                        read_q    <= L_READ;
                        be_q      <= L_BE;
                    end
                end
                S_ADDR: begin
                    state_q <= S_DATA;
                    doe_q   <= 1'b1;
                    ds_n_q  <= ~be_q;
                    // Reads release the address bus once the data phase begins.
                    if (read_q) begin
                        addr_oe_q <= 1'b0;
                    end
                end
                S_DATA: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                    if (wait_done_w) begin
                        state_q   <= S_TERM;
                        fcs_n_q   <= 1'b1;
                        doe_q     <= 1'b0;
                        ds_n_q    <= '1;
                        addr_oe_q <= 1'b0;
                        l_ack_q   <= !wait_err_w;
                        l_berr_q  <= wait_err_w;
                    end
                end
                S_TERM: begin
                    state_q <= S_RECOV;
                end
                S_RECOV: begin
                    // Hold off until the target has released both response lines.
                    if (dtk_s && berr_s) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign FCS_n   = fcs_n_q;
    assign DOE     = doe_q;
    assign DS_n    = ds_n_q;
    assign READ    = read_q;
    assign ADDR_OE = addr_oe_q;
    assign L_ACK   = l_ack_q;
    assign L_BERR  = l_berr_q;

endmodule

// File: tb/tb_z3_master_cycle.sv
// Bench for z3_master_cycle: each transfer is described by its response timing,
// from which the expected per-cycle output vector is derived as a bus-phase timeline.
module tb_z3_master_cycle;

    localparam int unsigned T = 8;
    localparam int unsigned S = 2;

    logic       CLK = 1'b0;
    logic       RESET_n;
    logic       MYBUS_n;
    logic       MASTER_n;
    logic       L_REQ;
    logic       L_READ;
    logic [3:0] L_BE;
    logic       L_ACK;
    logic       L_BERR;
    logic       FCS_n;
    logic       DOE;
    logic [3:0] DS_n;
    logic       READ;
    logic       ADDR_OE;
    logic       DTACK_n;
    logic       BERR_n;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    bit          last_rd;

    logic [9:0] obs_v;
    assign obs_v = {FCS_n, DOE, DS_n, READ, ADDR_OE, L_ACK, L_BERR};

    z3_master_cycle #(
        .TIMEOUT_CYCLES(T),
        .SYNC_STAGES   (S)
    ) dut (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .MYBUS_n (MYBUS_n),
        .MASTER_n(MASTER_n),
        .L_REQ   (L_REQ),
        .L_READ  (L_READ),
        .L_BE    (L_BE),
        .L_ACK   (L_ACK),
        .L_BERR  (L_BERR),
        .FCS_n   (FCS_n),
        .DOE     (DOE),
        .DS_n    (DS_n),
        .READ    (READ),
        .ADDR_OE (ADDR_OE),
        .DTACK_n (DTACK_n),
        .BERR_n  (BERR_n)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (FCS DOE DS[3:0] READ AOE ACK BERR)", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] idle_vec(input bit rd);
        return {1'b1, 1'b0, 4'hF, rd, 1'b0, 1'b0, 1'b0};
    endfunction

    // Bus phase after edge j of a cycle that started at edge 0 and terminates at edge e.
    function automatic logic [9:0] exp_vec(input int j, input int e, input bit err,
                                           input bit rd, input logic [3:0] be);
        if (j == 0)     return {1'b0, 1'b0, 4'hF, rd, 1'b1, 1'b0, 1'b0};
        else if (j < e) return {1'b0, 1'b1, ~be, rd, ~rd, 1'b0, 1'b0};
        else if (j == e) return {1'b1, 1'b0, 4'hF, rd, 1'b0, ~err, err};
        else            return idle_vec(rd);
    endfunction

    // One transfer. a: edge at which the response is first sampled low;
    // mode 0=DTACK, 1=BERR, 2=both, 3=none; hold: cycles response stays low after TERM;
    // keep: L_REQ left high for a back-to-back cycle; started: edge 0 is the next edge.
    task automatic run_txn(input bit rd, input logic [3:0] be, input int a, input int mode,
                           input int hold, input bit keep, input bit started, input bit wobble);
        int  r, e, rel, i, last;
        bit  err, asserted;
        r = a + int'(S);
        if (r < 3) r = 3;
        if (mode == 3 || r > int'(T) + 2) begin
            e   = int'(T) + 2;
            err = 1'b1;
        end else begin
            e   = r;
            err = (mode != 0);
        end
        rel      = e + 1 + hold;
        asserted = (mode != 3) && (a < rel);
        i        = e + 2;
        if (asserted && (a + int'(S) <= e + 2) && (e + 2 < rel + int'(S))) i = rel + int'(S);
        last = keep ? i : ((i > rel + int'(S)) ? i : rel + int'(S));

        if (!started) begin
            @(negedge CLK);
            L_REQ    = 1'b1;
            L_READ   = rd;
            L_BE     = be;
            MYBUS_n  = 1'b0;
            MASTER_n = 1'b0;
        end
        for (int j = 0; j <= last; j++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("m%0d_a%0d_h%0d_j%0d", mode, a, hold, j), obs_v, exp_vec(j, e, err, rd, be));
            if (j < last) begin
                @(negedge CLK);
                if (asserted && (j + 1 == a)) begin
                    if (mode != 1) DTACK_n = 1'b0;
                    if (mode != 0) BERR_n  = 1'b0;
                end
                if (j + 1 == rel) begin
                    DTACK_n = 1'b1;
                    BERR_n  = 1'b1;
                end
                if (wobble && j < e) begin
                    MYBUS_n  = 1'($urandom);
                    MASTER_n = 1'($urandom);
                    L_BE     = 4'($urandom);
                    if (j == 1 && !keep) L_REQ = 1'($urandom);
                end
                if (j == e) begin
                    MYBUS_n  = 1'b0;
                    MASTER_n = 1'b0;
                    if (!keep) L_REQ = 1'b0;
                end
            end
        end
        last_rd = rd;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_n  = 1'b0;
        MYBUS_n  = 1'b1;
        MASTER_n = 1'b1;
        L_REQ    = 1'b0;
        L_READ   = 1'b0;
        L_BE     = 4'h0;
        DTACK_n  = 1'b1;
        BERR_n   = 1'b1;
        last_rd  = 1'b1;

        #12;
        chk("reset", obs_v, idle_vec(1'b1));
        @(negedge CLK);
        RESET_n = 1'b1;
        repeat (3) @(negedge CLK);

        // Read, full width, DTACK three clocks into the data phase.
        run_txn(1'b1, 4'hF, 4, 0, 0, 1'b0, 1'b0, 1'b0);
        // Write BE=0011, DTACK one clock into the data phase.
        run_txn(1'b0, 4'b0011, 2, 0, 0, 1'b0, 1'b0, 1'b0);
        // No response: timeout after T wait cycles.
        run_txn(1'b1, 4'hA, 1, 3, 0, 1'b0, 1'b0, 1'b0);
        // BERR and DTACK together: error wins.
        run_txn(1'b0, 4'h5, 3, 2, 0, 1'b0, 1'b0, 1'b0);
        // Response first seen on the very edge the timeout fires: DTACK still wins.
        run_txn(1'b1, 4'h6, int'(T), 0, 0, 1'b0, 1'b0, 1'b0);
        // DTACK held 10 clocks after TERM with L_REQ high, then back-to-back cycle.
        run_txn(1'b1, 4'hC, 2, 0, 10, 1'b1, 1'b0, 1'b0);
        run_txn(1'b1, 4'hC, 2, 0, 0, 1'b0, 1'b1, 1'b0);

        // No grant or no local master: request is not taken.
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            L_REQ    = 1'b1;
            MYBUS_n  = (k == 0);
            MASTER_n = (k == 1);
            repeat (4) begin
                @(posedge CLK);
                #1;
                chk($sformatf("nogrant%0d", k), obs_v, idle_vec(last_rd));
            end
            @(negedge CLK);
            L_REQ    = 1'b0;
            MYBUS_n  = 1'b0;
            MASTER_n = 1'b0;
        end

        // Asynchronous reset while waiting for the target.
        @(negedge CLK);
        L_REQ  = 1'b1;
        L_READ = 1'b0;
        L_BE   = 4'h9;
        repeat (4) @(posedge CLK);
        #1;
        chk("pre_reset_wait", obs_v, exp_vec(3, 10, 1'b0, 1'b0, 4'h9));
        #1;
        RESET_n = 1'b0;
        #1;
        chk("async_reset", obs_v, idle_vec(1'b1));
        L_REQ = 1'b0;
        @(negedge CLK);
        RESET_n = 1'b1;
        repeat (4) begin
            @(posedge CLK);
            #1;
            chk("post_reset", obs_v, idle_vec(1'b1));
        end
        last_rd = 1'b1;

        // Randomised transfers, including grant/request wobble mid-cycle.
        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom), 4'($urandom), int'($urandom_range(1, 12)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    1'b0, 1'b0, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
